// File: rtl/nibble_alu_sequencer.sv
// Request/response sequencer for the nibble-serial ALU loop: decodes one operation,
// runs the loop under a watchdog, then returns the size-masked result and flags.
// loop_cmd packs {b_inv, cmd[1:0]}; cmd 0=ADD, 1=RSHFT, 2=XNOR.
module nibble_alu_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_carry,
  output logic        rsp_zero,
  output logic        rsp_eq,
  output logic        rsp_error,
  output logic        loop_perm,
  output logic [2:0]  loop_cmd,
  output logic [2:0]  loop_nibbles,
  output logic        loop_check_0xf,
  output logic        loop_w2_neg,
  output logic [31:0] loop_word1,
  output logic [31:0] loop_word2,
  output logic [31:0] loop_preinit,
  output logic        loop_carry_init,
  input  logic        loop_carry,
  input  logic        loop_busy,
  input  logic [31:0] loop_result
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [2:0] OP_ADD   = 3'd0;
  localparam logic [2:0] OP_SUB   = 3'd1;
  localparam logic [2:0] OP_RSHFT = 3'd2;
  localparam logic [2:0] OP_EQ    = 3'd3;

  localparam logic [1:0] CMD_ADD   = 2'd0;
  localparam logic [1:0] CMD_RSHFT = 2'd1;
  localparam logic [1:0] CMD_XNOR  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_RUN, S_RESP} state_t;

  state_t r_state;
  state_t w_next;

  logic [WD_W-1:0] r_wdog;
  logic            r_started;
  logic            r_is_eq;
  logic [31:0]     r_mask;
  logic [2:0]      r_cmd;
  logic [2:0]      r_nibbles;
  logic            r_check_0xf;
  logic            r_w2_neg;
  logic [31:0]     r_word1;
  logic [31:0]     r_word2;
  logic [31:0]     r_preinit;
  logic            r_carry_init;

  logic [31:0]     r_rsp_result;
  logic            r_rsp_carry;
  logic            r_rsp_zero;
  logic            r_rsp_eq;
  logic            r_rsp_error;

  logic [31:0]     w_dec_mask;
  logic [2:0]      w_dec_nib;
  logic            w_dec_sign;
  logic [2:0]      w_dec_cmd;
  logic            w_dec_cin;
  logic            w_dec_chk;
  logic            w_dec_w2neg;
  logic [31:0]     w_dec_pre;
  logic            w_reserved;

  logic            w_accept;
  logic            w_first;
  logic            w_capture;
  logic            w_timeout;
  logic [31:0]     w_masked;

  // Request decode into loop controls
  always_comb begin
    w_dec_mask  = '0;
    w_dec_nib   = '0;
    w_dec_sign  = 1'b0;
    w_dec_cmd   = '0;
    w_dec_cin   = 1'b0;
    w_dec_chk   = 1'b0;
    w_dec_w2neg = 1'b0;
    w_dec_pre   = '0;
    case (req_size)
      2'd0: begin w_dec_mask = 32'h0000_00FF; w_dec_nib = 3'd1; w_dec_sign = req_b[7];  end
      2'd1: begin w_dec_mask = 32'h0000_FFFF; w_dec_nib = 3'd3; w_dec_sign = req_b[15]; end
      2'd2: begin w_dec_mask = 32'hFFFF_FFFF; w_dec_nib = 3'd7; w_dec_sign = req_b[31]; end
      default: ;
    endcase
    case (req_op)
      OP_ADD: begin
        w_dec_cmd   = {1'b0, CMD_ADD};
        w_dec_pre   = req_a;
        w_dec_w2neg = req_signed && w_dec_sign;
      end
      OP_SUB: begin
        w_dec_cmd = {1'b1, CMD_ADD};
        w_dec_cin = 1'b1;
        w_dec_pre = req_a;
      end
      OP_RSHFT: w_dec_cmd = {1'b0, CMD_RSHFT};
      OP_EQ: begin
        w_dec_cmd = {1'b0, CMD_XNOR};
        w_dec_cin = 1'b1;
        w_dec_chk = 1'b1;
      end
      default: ;
    endcase
    w_reserved = (req_op > OP_EQ) || (req_size == 2'd3);
  end

  // Busy is ignored on the first RUN cycle since the loop raises it combinationally
  always_comb begin
    w_accept  = (r_state == S_IDLE) && req_valid;
    w_first   = (r_wdog == '0);
    w_capture = (r_state == S_RUN) && !w_first && !loop_busy;
    w_timeout = (r_state == S_RUN) && !w_capture &&
                (r_wdog == WD_W'(TIMEOUT_CYCLES - 1));
    w_masked  = loop_result & r_mask;

    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    loop_perm = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = w_reserved ? S_RESP : S_SETUP;
      end
      S_SETUP: w_next = S_RUN;
      S_RUN: begin
        loop_perm = 1'b1;
        if (w_capture || w_timeout) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        loop_perm = r_started;
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wdog  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_RUN) r_wdog <= r_wdog + WD_W'(1);
      else                  r_wdog <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_started    <= 1'b0;
      r_is_eq      <= 1'b0;
      r_mask       <= '0;
      r_cmd        <= '0;
      r_nibbles    <= '0;
      r_check_0xf  <= 1'b0;
      r_w2_neg     <= 1'b0;
      r_word1      <= '0;
      r_word2      <= '0;
      r_preinit    <= '0;
      r_carry_init <= 1'b0;
    end else if (w_accept) begin
      r_started    <= !w_reserved;
      r_is_eq      <= (req_op == OP_EQ);
      r_mask       <= w_dec_mask;
      r_cmd        <= w_dec_cmd;
      r_nibbles    <= w_dec_nib;
      r_check_0xf  <= w_dec_chk;
      r_w2_neg     <= w_dec_w2neg;
      r_word1      <= req_a;
      r_word2      <= req_b;
      r_preinit    <= w_dec_pre;
      r_carry_init <= w_dec_cin;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_eq     <= 1'b0;
      r_rsp_error  <= 1'b0;
    end else if ((w_accept && w_reserved) || w_timeout) begin
      r_rsp_result <= '0;
      r_rsp_carry  <= 1'b0;
      r_rsp_zero   <= 1'b0;
      r_rsp_eq     <= 1'b0;
      r_rsp_error  <= 1'b1;
    end else if (w_capture) begin
      r_rsp_error <= 1'b0;
      if (r_is_eq) begin
        r_rsp_result <= '0;
        r_rsp_carry  <= 1'b0;
        r_rsp_zero   <= 1'b0;
        r_rsp_eq     <= loop_carry;
      end else begin
        r_rsp_result <= w_masked;
        r_rsp_carry  <= loop_carry;
        r_rsp_zero   <= (w_masked == '0);
        r_rsp_eq     <= 1'b0;
      end
    end
  end

  assign rsp_result      = r_rsp_result;
  assign rsp_carry       = r_rsp_carry;
  assign rsp_zero        = r_rsp_zero;
  assign rsp_eq          = r_rsp_eq;
  assign rsp_error       = r_rsp_error;
  assign loop_cmd        = r_cmd;
  assign loop_nibbles    = r_nibbles;
  assign loop_check_0xf  = r_check_0xf;
  assign loop_w2_neg     = r_w2_neg;
  assign loop_word1      = r_word1;
  assign loop_word2      = r_word2;
  assign loop_preinit    = r_preinit;
  assign loop_carry_init = r_carry_init;

endmodule
